// File: rtl/hazard_ctrl_unit.sv
// ID-stage hazard/bubble controller: load-use stalls, taken-branch flushes, and a saturating bubble counter.
// Outputs are Mealy (same cycle); stall/flush effects show up at the next clock edge.
module hazard_ctrl_unit #(
    parameter int FLUSH_CYC = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       id_opcode,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rd,
    input  logic             branch_taken,
    input  logic             cnt_clr,
    output logic             CtrlSrc,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IFIDFlush,
    output logic [CNT_W-1:0] bubble_cnt
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] LU_STALL = 2'd1;
    localparam logic [1:0] BR_FLUSH = 2'd2;

    // A single-cycle flush never leaves IDLE, so the reload value only matters when FLUSH_CYC > 1.
    localparam logic [3:0] RELOAD  = (FLUSH_CYC > 1) ? 4'(FLUSH_CYC - 2) : 4'd0;
    localparam logic [1:0] BR_NEXT = (FLUSH_CYC > 1) ? BR_FLUSH : IDLE;

    logic [1:0] state, state_nxt;
    logic [3:0] fcnt, fcnt_nxt;
    logic       use_rs1, use_rs2, lu_haz;

    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (id_opcode)
            7'b0110011, 7'b0100011, 7'b1100011: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            7'b0010011, 7'b0000011: use_rs1 = 1'b1;
            default: ;
        endcase
    end

    assign lu_haz = ex_memread && (ex_rd != 5'd0) &&
                    ((use_rs1 && (id_rs1 == ex_rd)) || (use_rs2 && (id_rs2 == ex_rd)));

    always_comb begin
        CtrlSrc   = 1'b0;
        PCWrite   = 1'b1;
        IFIDWrite = 1'b1;
        IFIDFlush = 1'b0;
        state_nxt = IDLE;
        fcnt_nxt  = fcnt;
        case (state)
            BR_FLUSH: begin
                CtrlSrc   = 1'b1;
                IFIDFlush = 1'b1;
                if (branch_taken) begin
                    state_nxt = BR_FLUSH;
                    fcnt_nxt  = RELOAD;
                end else if (fcnt != 4'd0) begin
                    state_nxt = BR_FLUSH;
                    fcnt_nxt  = fcnt - 4'd1;
                end
            end
            default: begin
                if (branch_taken) begin
                    CtrlSrc   = 1'b1;
                    IFIDFlush = 1'b1;
                    state_nxt = BR_NEXT;
                    fcnt_nxt  = RELOAD;
                end else if (state == IDLE && lu_haz) begin
                    // In LU_STALL the bubble is already in ID/EX, so the hazard is masked there.
                    CtrlSrc   = 1'b1;
                    PCWrite   = 1'b0;
                    IFIDWrite = 1'b0;
                    state_nxt = LU_STALL;
                end
            end
        endcase
        if (rst) begin
            CtrlSrc   = 1'b1;
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            IFIDFlush = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            fcnt  <= 4'd0;
        end else begin
            state <= state_nxt;
            fcnt  <= fcnt_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt <= '0;
        end else if (cnt_clr) begin
            bubble_cnt <= '0;
        end else if (CtrlSrc && !(&bubble_cnt)) begin
            bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit: three instances (FLUSH_CYC=1, FLUSH_CYC=3, CNT_W=4) share one stimulus.
module tb_hazard_ctrl_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] id_opcode;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       ex_memread, branch_taken, cnt_clr;

    logic        cs_a, pw_a, iw_a, fl_a;
    logic        cs_b, pw_b, iw_b, fl_b;
    logic        cs_c, pw_c, iw_c, fl_c;
    logic [15:0] cnt_a, cnt_b;
    logic [3:0]  cnt_c;
    logic [3:0]  out_a, out_b, out_c;

    int n_chk  = 0;
    int n_fail = 0;

    localparam logic [3:0] PASS  = 4'b0110;
    localparam logic [3:0] STALL = 4'b1000;
    localparam logic [3:0] FLUSH = 4'b1111;
    localparam logic [3:0] RST   = 4'b1001;

    assign out_a = {cs_a, pw_a, iw_a, fl_a};
    assign out_b = {cs_b, pw_b, iw_b, fl_b};
    assign out_c = {cs_c, pw_c, iw_c, fl_c};

    always #5 clk = ~clk;

    hazard_ctrl_unit #(.FLUSH_CYC(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .ex_memread(ex_memread), .ex_rd(ex_rd), .branch_taken(branch_taken), .cnt_clr(cnt_clr),
        .CtrlSrc(cs_a), .PCWrite(pw_a), .IFIDWrite(iw_a), .IFIDFlush(fl_a), .bubble_cnt(cnt_a));

    hazard_ctrl_unit #(.FLUSH_CYC(3), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .ex_memread(ex_memread), .ex_rd(ex_rd), .branch_taken(branch_taken), .cnt_clr(cnt_clr),
        .CtrlSrc(cs_b), .PCWrite(pw_b), .IFIDWrite(iw_b), .IFIDFlush(fl_b), .bubble_cnt(cnt_b));

    hazard_ctrl_unit #(.FLUSH_CYC(1), .CNT_W(4)) dut_c (
        .clk(clk), .rst(rst), .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .ex_memread(ex_memread), .ex_rd(ex_rd), .branch_taken(branch_taken), .cnt_clr(cnt_clr),
        .CtrlSrc(cs_c), .PCWrite(pw_c), .IFIDWrite(iw_c), .IFIDFlush(fl_c), .bubble_cnt(cnt_c));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("assertion %s", tag);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; id_opcode = 7'd0; id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
        ex_memread = 1'b0; branch_taken = 1'b0; cnt_clr = 1'b0;
        #2;
        chk("reset_out_a", out_a, RST);
        chk("reset_cnt_a", cnt_a, 0);
        tick(); tick();
        rst = 1'b0; #1;
        chk("post_reset_pass_a", out_a, PASS);

        // T1: lw x5 followed by add x7,x5,x6
        ex_memread = 1'b1; ex_rd = 5'd5; id_opcode = 7'b0110011; id_rs1 = 5'd5; id_rs2 = 5'd6; #1;
        chk("t1_stall_a", out_a, STALL);
        tick();
        chk("t1_lustall_masked_a", out_a, PASS);
        chk("t1_cnt_a", cnt_a, 1);
        ex_memread = 1'b0; tick();
        chk("t1_idle_pass_a", out_a, PASS);

        // T2: rs2 ignored for addi, used for sw
        ex_memread = 1'b1; ex_rd = 5'd6; id_opcode = 7'b0010011; id_rs1 = 5'd1; id_rs2 = 5'd6; #1;
        chk("t2_addi_no_stall_a", out_a, PASS);
        id_opcode = 7'b0100011; #1;
        chk("t2_sw_stall_a", out_a, STALL);
        tick();
        chk("t2_lustall_a", out_a, PASS);
        ex_memread = 1'b0; tick();
        chk("t2_cnt_a", cnt_a, 2);

        // T3: x0 never hazards; jal uses no sources
        ex_memread = 1'b1; ex_rd = 5'd0; id_opcode = 7'b0110011; id_rs1 = 5'd0; id_rs2 = 5'd0; #1;
        chk("t3_x0_no_stall_a", out_a, PASS);
        ex_rd = 5'd5; id_opcode = 7'b1101111; id_rs1 = 5'd5; id_rs2 = 5'd5; #1;
        chk("t3_jal_no_stall_a", out_a, PASS);
        ex_memread = 1'b0; cnt_clr = 1'b1; tick();
        cnt_clr = 1'b0;
        chk("clr_cnt_a", cnt_a, 0);
        chk("clr_cnt_b", cnt_b, 0);

        // T4: branch and load-use together -> flush wins
        ex_memread = 1'b1; ex_rd = 5'd5; id_opcode = 7'b0110011; id_rs1 = 5'd5; branch_taken = 1'b1; #1;
        chk("t4_flush_a", out_a, FLUSH);
        chk("t4_flush_b0", out_b, FLUSH);
        tick();
        branch_taken = 1'b0; ex_memread = 1'b0; #1;
        chk("t4_done_a", out_a, PASS);
        chk("t4_flush_b1", out_b, FLUSH);
        chk("t4_cnt_a", cnt_a, 1);
        tick();
        ex_memread = 1'b1; #1;
        chk("t4_flush_b2_ignores_haz", out_b, FLUSH);
        chk("t4_stall_a", out_a, STALL);
        tick();
        ex_memread = 1'b0; #1;
        chk("t4_done_b", out_b, PASS);
        chk("t4_cnt_b", cnt_b, 3);
        chk("t4_cnt_a2", cnt_a, 2);
        tick();

        // Branch arriving during LU_STALL
        ex_memread = 1'b1; #1;
        chk("lsbr_stall_a", out_a, STALL);
        tick();
        ex_memread = 1'b0; branch_taken = 1'b1; #1;
        chk("lsbr_flush_a", out_a, FLUSH);
        chk("lsbr_flush_b", out_b, FLUSH);
        tick();
        branch_taken = 1'b0; #1;
        chk("lsbr_idle_a", out_a, PASS);
        chk("lsbr_hold_b", out_b, FLUSH);
        tick();
        chk("lsbr_hold2_b", out_b, FLUSH);
        tick();
        chk("lsbr_idle_b", out_b, PASS);

        // T5: saturation at CNT_W=4 and clear priority
        branch_taken = 1'b1; cnt_clr = 1'b1; #1;
        chk("t5_ctrlsrc_c", cs_c, 1);
        tick();
        cnt_clr = 1'b0;
        chk("t5_clr_c", cnt_c, 0);
        repeat (15) tick();
        chk("t5_cnt15_c", cnt_c, 15);
        repeat (5) tick();
        chk("t5_sat_c", cnt_c, 15);
        chk("t5_nosat_a", cnt_a, 20);
        cnt_clr = 1'b1; tick();
        cnt_clr = 1'b0;
        chk("t5_clr_busy_c", cnt_c, 0);
        branch_taken = 1'b0;
        repeat (3) tick();
        #1;
        chk("t5_settled_b", out_b, PASS);

        // T6: reset in cycle 2 of a 3-cycle flush
        branch_taken = 1'b1; #1;
        chk("t6_flush_b0", out_b, FLUSH);
        tick();
        branch_taken = 1'b0; #1;
        chk("t6_flush_b1", out_b, FLUSH);
        rst = 1'b1; #1;
        chk("t6_reset_out_b", out_b, RST);
        chk("t6_reset_cnt_b", cnt_b, 0);
        branch_taken = 1'b1; ex_memread = 1'b1; tick();
        chk("t6_reset_forced_b", out_b, RST);
        chk("t6_reset_forced_a", out_a, RST);
        rst = 1'b0; branch_taken = 1'b0; ex_memread = 1'b0; #1;
        chk("t6_release_b", out_b, PASS);
        chk("t6_release_cnt_b", cnt_b, 0);
        tick();
        chk("t6_idle_b", out_b, PASS);
        chk("t6_idle_cnt_b", cnt_b, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
